// File: rtl/sram_wb_pkg.sv
// sram_wb_pkg: state encoding and shared constants for the Wishbone-to-SRAM responder.
`default_nettype none

package sram_wb_pkg;

  localparam int          WAIT_CNT_W        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    WRITE_HOLD = 3'd3,
    DONE       = 3'd4,
    ERR        = 3'd5
  } sram_wb_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_wb_slave_if.sv
// sram_wb_slave_if: Wishbone classic bus between a master and the SRAM responder.
`default_nettype none

interface sram_wb_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic                    wb_ack_o;
  logic                    wb_err_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

`default_nettype wire

// File: rtl/sram_data_iobuf.sv
// sram_data_iobuf: tristate pad for the SRAM data bus; the drive enable is registered
// so the bus is released on a clock edge (or immediately by reset), never by a wb input.
`default_nettype none

module sram_data_iobuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  oe_next,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] in_data,
  inout  wire  [DATA_WIDTH-1:0] pad
);

  logic oe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oe <= 1'b0;
    end else begin
      oe <= oe_next;
    end
  end

  assign pad     = oe ? out_data : {DATA_WIDTH{1'bz}};
  assign in_data = pad;

endmodule

`default_nettype wire

// File: rtl/sram_wb_slave.sv
// sram_wb_slave: Wishbone classic responder sequencing an async SRAM with WAIT_CYCLES strobes.
// Define SRAM_WB_SLAVE_RANGE_CHECK_EN to error-terminate accesses outside the SRAM window.
`default_nettype none

module sram_wb_slave
  import sram_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    SRAM_ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    WAIT_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_wb_slave_if.slave             wb,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0]      sram_data,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [DATA_WIDTH/8-1:0]    sram_be_n
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  sram_wb_state_t          state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    aborted;
  logic                    ack_q;
  logic                    err_q;
  logic                    req;
  logic                    req_ok;
  logic                    drive_next;
  logic                    unused_adr_bits;

  assign req = wb.wb_cyc_i && wb.wb_stb_i;

`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH+1:0] WIN_LO   = {2'b00, BASE_ADDR};
  localparam logic [ADDR_WIDTH+1:0] WIN_SPAN = (ADDR_WIDTH+2)'(1) << (SRAM_ADDR_WIDTH + 2);
  logic [ADDR_WIDTH+1:0] adr_ext;
  assign adr_ext = {2'b00, wb.wb_adr_i};
  assign req_ok  = (adr_ext >= WIN_LO) && (adr_ext < WIN_LO + WIN_SPAN);
`else
  assign req_ok  = 1'b1;
`endif

  // Bits outside the word index only matter to the optional window check.
  assign unused_adr_bits = ^{wb.wb_adr_i[1:0], wb.wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], BASE_ADDR};

  // Next-cycle drive enable; the iobuf registers it.
  assign drive_next = (state == IDLE && req && wb.wb_we_i && req_ok) || (state == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_data   <= '0;
      rd_data   <= '0;
      aborted   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
            if (!req_ok) begin
              state <= ERR;
              err_q <= 1'b1;
            end else
`endif
            begin
              sram_addr <= wb.wb_adr_i[SRAM_ADDR_WIDTH+1:2];
              wr_data   <= wb.wb_dat_i;
              sram_be_n <= ~wb.wb_sel_i;
              wait_cnt  <= WAIT_LOAD;
              aborted   <= 1'b0;
              sram_ce_n <= 1'b0;
              if (wb.wb_we_i) begin
                sram_we_n <= 1'b0;
                state     <= WRITE;
              end else begin
                sram_oe_n <= 1'b0;
                state     <= READ;
              end
            end
          end
        end
        READ: begin
          aborted <= aborted || !wb.wb_cyc_i;
          if (wait_cnt == '0) begin
            rd_data   <= data_in;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
            ack_q     <= wb.wb_cyc_i && !aborted;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WRITE: begin
          aborted <= aborted || !wb.wb_cyc_i;
          if (wait_cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WRITE_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WRITE_HOLD: begin
          aborted   <= aborted || !wb.wb_cyc_i;
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          ack_q     <= wb.wb_cyc_i && !aborted;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
        ERR: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q;
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
  assign wb.wb_err_o = err_q;
`else
  assign wb.wb_err_o = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif
  assign wb.wb_dat_o = rd_data;

  sram_data_iobuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iobuf (
    .clk      (clk),
    .reset    (reset),
    .oe_next  (drive_next),
    .out_data (wr_data),
    .in_data  (data_in),
    .pad      (sram_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_wb_slave.sv
// tb_sram_wb_slave: scoreboard bench for sram_wb_slave with SRAM models for WAIT_CYCLES=2 and =1.
`default_nettype none

module tb_sram_wb_slave;
  import sram_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic [3:0]  sel [2];
  logic        ack [2];
  logic        err [2];
  logic [31:0] rdat[2];

  logic [19:0] s_addr[2];
  logic        s_ce  [2];
  logic        s_oe  [2];
  logic        s_we  [2];
  logic [3:0]  s_be  [2];
  logic        drv   [2];
  logic [2:0]  st    [2];
  wire  [31:0] sd0;
  wire  [31:0] sd1;

  sram_wb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb0 ();
  sram_wb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb1 ();

  assign wb0.wb_cyc_i = cyc[0];  assign wb1.wb_cyc_i = cyc[1];
  assign wb0.wb_stb_i = stb[0];  assign wb1.wb_stb_i = stb[1];
  assign wb0.wb_we_i  = we[0];   assign wb1.wb_we_i  = we[1];
  assign wb0.wb_adr_i = adr[0];  assign wb1.wb_adr_i = adr[1];
  assign wb0.wb_dat_i = wdat[0]; assign wb1.wb_dat_i = wdat[1];
  assign wb0.wb_sel_i = sel[0];  assign wb1.wb_sel_i = sel[1];
  assign ack[0]  = wb0.wb_ack_o; assign ack[1]  = wb1.wb_ack_o;
  assign err[0]  = wb0.wb_err_o; assign err[1]  = wb1.wb_err_o;
  assign rdat[0] = wb0.wb_dat_o; assign rdat[1] = wb1.wb_dat_o;

  sram_wb_slave #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst_n), .wb(wb0), .sram_addr(s_addr[0]), .sram_data(sd0),
    .sram_ce_n(s_ce[0]), .sram_oe_n(s_oe[0]), .sram_we_n(s_we[0]), .sram_be_n(s_be[0])
  );
  sram_wb_slave #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst_n), .wb(wb1), .sram_addr(s_addr[1]), .sram_data(sd1),
    .sram_ce_n(s_ce[1]), .sram_oe_n(s_oe[1]), .sram_we_n(s_we[1]), .sram_be_n(s_be[1])
  );

  assign drv[0] = dut0.u_iobuf.oe;  assign drv[1] = dut1.u_iobuf.oe;
  assign st[0]  = dut0.state;       assign st[1]  = dut1.state;

  // Asynchronous SRAM models: drive on read strobes, byte-lane write on each clk with we_n low.
  logic [31:0] mem0 [0:(1<<20)-1];
  logic [31:0] mem1 [0:(1<<20)-1];
  logic [31:0] rd0, rd1;
  assign rd0 = mem0[s_addr[0]];
  assign rd1 = mem1[s_addr[1]];
  assign sd0 = (!s_ce[0] && !s_oe[0] && s_we[0]) ? rd0 : 32'bz;
  assign sd1 = (!s_ce[1] && !s_oe[1] && s_we[1]) ? rd1 : 32'bz;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!s_ce[0] && !s_we[0] && !s_be[0][b]) mem0[s_addr[0]][8*b +: 8] <= sd0[8*b +: 8];
      if (!s_ce[1] && !s_we[1] && !s_be[1][b]) mem1[s_addr[1]][8*b +: 8] <= sd1[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    bit          resp;
    bit          is_err;
    int          lat;
    int          ce_cnt;
    int          oe_cnt;
    int          we_cnt;
    int          drv_cnt;
    logic [19:0] addr;
    logic [3:0]  be;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd[2] = '{32'h0, 32'h0};

  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input int abort_at, input logic [31:0] exp_rd,
                      input string tag);
    exp_t e;
    int   wc = (d == 0) ? 2 : 1;
    bit   is_err = 1'b0;
    int   n = 0, lat = 0, extra = 0, ce_c = 0, oe_c = 0, we_c = 0, drv_c = 0;
    bit   got_err = 1'b0;
    logic [19:0] addr_seen = '0;
    logic [3:0]  be_seen = '0;
`ifdef SRAM_WB_SLAVE_RANGE_CHECK_EN
    is_err = (a < 32'h8000_0000) || (a >= 32'h8040_0000);
`endif
    e.tag      = tag;
    e.resp     = (abort_at == 0);
    e.is_err   = is_err;
    e.lat      = is_err ? 1 : (w ? wc + 2 : wc + 1);
    e.ce_cnt   = is_err ? 0 : (w ? wc + 1 : wc);
    e.oe_cnt   = (w || is_err) ? 0 : wc;
    e.we_cnt   = (!w && !is_err) ? 0 : (is_err ? 0 : wc);
    e.drv_cnt  = (w && !is_err) ? wc + 1 : 0;
    e.addr     = a[21:2];
    e.be       = ~s;
    e.chk_data = (abort_at == 0);
    e.data     = (w || is_err) ? last_rd[d] : exp_rd;
    sb.push_back(e);
    if (!w && !is_err && abort_at == 0) last_rd[d] = exp_rd;

    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
    @(posedge clk);
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (!s_ce[d]) ce_c++;
      if (!s_oe[d]) oe_c++;
      if (drv[d])   drv_c++;
      if (!s_we[d]) begin we_c++; be_seen = s_be[d]; end
      if (n == 1) begin addr_seen = s_addr[d]; if (!w) be_seen = s_be[d]; end
      if (n == abort_at) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
      if (ack[d] || err[d]) begin
        if (lat == 0) begin lat = n; got_err = err[d]; end
        else extra++;
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end
      if (lat != 0 && n == lat + 2) break;
      if (abort_at != 0 && n == 8) break;
    end

    e = sb.pop_front();
    check({e.tag, ":latency"}, lat, e.resp ? e.lat : 0);
    check({e.tag, ":ce_cycles"}, ce_c, e.ce_cnt);
    check({e.tag, ":oe_cycles"}, oe_c, e.oe_cnt);
    check({e.tag, ":we_cycles"}, we_c, e.we_cnt);
    check({e.tag, ":drive_cycles"}, drv_c, e.drv_cnt);
    if (e.resp) begin
      check({e.tag, ":err_flag"}, {31'b0, got_err}, {31'b0, e.is_err});
      check({e.tag, ":extra_pulses"}, extra, 0);
    end
    if (!e.is_err) begin
      check({e.tag, ":sram_addr"}, {12'b0, addr_seen}, {12'b0, e.addr});
      check({e.tag, ":be_n"}, {28'b0, be_seen}, {28'b0, e.be});
    end
    if (e.chk_data) check({e.tag, ":dat_o"}, rdat[d], e.data);
  endtask

  task automatic reset_mid_write();
    int acks = 0;
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h8000_0300;
    wdat[0] = 32'h0000_0077; sel[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("rst:in_write_we", {31'b0, s_we[0]}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst:we_n", {31'b0, s_we[0]}, 32'h1);
    check("rst:ce_n", {31'b0, s_ce[0]}, 32'h1);
    check("rst:bus_drive", {31'b0, drv[0]}, 32'h0);
    check("rst:state", {29'b0, st[0]}, {29'b0, IDLE});
    check("rst:ack", {31'b0, ack[0]}, 32'h0);
    check("rst:dat_o", rdat[0], 32'h0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 32'h0;
    repeat (5) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    check("rst:no_ack_after", acks, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = '0; wdat[i] = '0; sel[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset:ack", {31'b0, ack[0]}, 32'h0);
    check("reset:err", {31'b0, err[0]}, 32'h0);
    check("reset:dat_o", rdat[0], 32'h0);
    check("reset:sram_addr", {12'b0, s_addr[0]}, 32'h0);
    check("reset:strobes", {29'b0, s_ce[0], s_oe[0], s_we[0]}, 32'h7);
    check("reset:be_n", {28'b0, s_be[0]}, 32'hF);
    check("reset:bus_drive", {31'b0, drv[0]}, 32'h0);
    check("reset:state", {29'b0, st[0]}, {29'b0, IDLE});
    rst_n = 1'b1;

    xact(0, 1'b1, 32'h8000_0040, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, "wr_pre_dead");
    xact(0, 1'b1, 32'h8000_0000, 32'hAAAA_AAAA, 4'hF, 0, 32'h0, "wr_pre_aaaa");
    xact(0, 1'b1, 32'h8000_0080, 32'h1234_5678, 4'hF, 0, 32'h0, "wr_pre_1234");
    xact(0, 1'b1, 32'h803F_FFFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, "wr_pre_top");
    xact(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, "rd_basic");
    xact(0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'b0101, 0, 32'h0, "wr_lanes");
    xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 32'hAA22_AA44, "rd_lanes");
    xact(0, 1'b1, 32'h8000_0080, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, "wr_nosel");
    xact(0, 1'b0, 32'h8000_0080, 32'h0, 4'hF, 0, 32'h1234_5678, "rd_nosel");
    xact(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, "rd_abort");
    xact(0, 1'b0, 32'h8000_0080, 32'h0, 4'hF, 0, 32'h1234_5678, "rd_after_abort");
    xact(0, 1'b1, 32'h8000_0200, 32'h0000_0055, 4'hF, 2, 32'h0, "wr_abort");
    xact(0, 1'b0, 32'h8000_0200, 32'h0, 4'hF, 0, 32'h0000_0055, "rd_after_wabort");
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, 0, 32'hCAFE_F00D, "rd_range");
    reset_mid_write();
    xact(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, "rd_post_rst");

    xact(1, 1'b1, 32'h8000_0014, 32'hA5A5_A5A5, 4'hF, 0, 32'h0, "w1_pre");
    xact(1, 1'b0, 32'h8000_0014, 32'h0, 4'hF, 0, 32'hA5A5_A5A5, "w1_rd");
    xact(1, 1'b1, 32'h8000_0018, 32'h0102_0304, 4'hF, 0, 32'h0, "w1_wr");
    xact(1, 1'b0, 32'h8000_0018, 32'h0, 4'hF, 0, 32'h0102_0304, "w1_rdback");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
